wb_capture_stage: RTL and testbench
===================================

Name: wb_capture_stage

Overview:
- Writeback capture stage directly downstream of the 4-source 32-bit result select mux.
- Accepts each selected result (mux output, the 2-bit select code that produced it, destination register index) over a valid/ready handshake.
- Buffers results in a 2-entry skid FIFO and presents them to the register-file write port with its own valid/ready.
- Keeps one saturating per-source result counter for each of the four select codes, for debug.

Parameters:
- DATA_W, 32, width of result data.
- RD_W, 3, width of destination register index.
- CNT_W, 16, width of each per-source counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result.
- in_data  input  DATA_W  selected result (mux output O).
- in_sel  input  2  select code {C1,C0} that produced in_data.
- in_rd  input  RD_W  destination register index.
- out_valid  output  1  head entry valid.
- out_ready  input  1  register file accepts head entry.
- out_data  output  DATA_W  head entry data.
- out_sel  output  2  head entry select code.
- out_rd  output  RD_W  head entry destination.
- occupancy  output  2  entries held (0..2).
- cnt_clr  input  1  synchronous clear of all counters.
- cnt_sel  input  2  counter read select.
- cnt_value  output  CNT_W  counter[cnt_sel], combinational read.

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled on the clk rising edge with reset_n=0.
- Reset values: FIFO empty, out_valid=0, out_data=0, out_sel=0, out_rd=0, occupancy=0, all counters=0, in_ready=0.
- in_ready is registered. It reads 1 from the first edge at which reset_n is sampled 1. After that, in_ready = (occupancy after this edge < 2).
- Push when in_valid & in_ready; pop when out_valid & out_ready. Both are evaluated at the clk edge.
- Latency: a push into an empty FIFO makes out_valid=1 with that entry's data on the next cycle. There is no combinational in-to-out path.
- FIFO order is strict; out_* always shows the oldest entry.
- While out_valid=1 and out_ready=0, out_data, out_sel and out_rd stay stable.
- Simultaneous push and pop at occupancy 1: occupancy stays 1, the new entry becomes head, in_ready stays 1.
- At occupancy 2, in_ready=0 and no push is possible. A pop takes occupancy to 1 and in_ready goes to 1 on the next cycle.
- Simultaneous push and pop at occupancy 0 cannot occur, because out_valid=0.
- in_rd==0 (hard-wired zero register): the result is accepted (handshake completes) but not enqueued. The counter still increments.
- Counters: counter[in_sel] increments by 1 on every accepted push, including rd=0.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr=1 zeroes all counters on that edge and takes priority over a same-cycle increment. That increment is lost.
- Reset mid-operation: FIFO contents are discarded, the in-flight handshake is ignored, and all state returns to reset values on that edge.
- Input data with in_valid=0 is ignored. X on in_data when in_valid=0 must not propagate into the FIFO.

Test Plan:
1. Reset release, then in_valid=1, in_data=0xDEADBEEF, in_sel=2, in_rd=5, out_ready=1 -> one cycle later out_valid=1, out_data=0xDEADBEEF, out_sel=2, out_rd=5; the next cycle out_valid=0; cnt_sel=2 reads cnt_value=1.
2. out_ready=0; push 0x11111111 (rd1), then 0x22222222 (rd2) -> occupancy=2, in_ready=0, and a third in_valid is not accepted. Raise out_ready -> outputs 0x11111111 then 0x22222222 in order; in_ready returns to 1 one cycle after the first pop.
3. Occupancy 1 with continuous push and pop for 10 cycles, data 0..9 -> occupancy stays 1, in_ready stays 1, out_data sequence is 0..9 with no gaps or duplicates.
4. Push in_rd=0, in_sel=1, in_data=0xCAFEF00D -> handshake completes, out_valid stays 0, counter[1]=1.
5. Preload counter[3]=0xFFFE, then two pushes with sel=3 -> counter saturates at 0xFFFF. cnt_clr asserted together with a sel=0 push -> all counters read 0.
6. reset_n=0 for one cycle while occupancy=2 and out_ready=0 -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=0, counters=0; in_ready=1 on the following cycle.

Source files
------------

// File: rtl/wb_capture_stage.sv
// rtl/wb_capture_stage.sv - writeback capture stage: 2-entry skid FIFO plus per-source result counters
module wb_capture_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  input  logic [1:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_value
);

  logic              r_in_ready;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_head_data, r_tail_data;
  logic [1:0]        r_head_sel, r_tail_sel;
  logic [RD_W-1:0]   r_head_rd, r_tail_rd;
  logic [CNT_W-1:0]  r_cnt [4];

  logic       w_push;
  logic       w_enq;
  logic       w_pop;
  logic [1:0] w_occ_nxt;

  // Writes to the zero register complete the handshake but never occupy a slot.
  assign w_push = in_valid & r_in_ready;
  assign w_enq  = w_push & (in_rd != '0);
  assign w_pop  = (r_occ != 2'd0) & out_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_enq, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_ready  <= 1'b0;
      r_occ       <= 2'd0;
      r_head_data <= '0;
      r_head_sel  <= '0;
      r_head_rd   <= '0;
      r_tail_data <= '0;
      r_tail_sel  <= '0;
      r_tail_rd   <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_in_ready <= (w_occ_nxt != 2'd2);
      r_occ      <= w_occ_nxt;

      if ((r_occ == 2'd2) && w_pop) begin
        r_head_data <= r_tail_data;
        r_head_sel  <= r_tail_sel;
        r_head_rd   <= r_tail_rd;
      end else if (w_enq && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop))) begin
        r_head_data <= in_data;
        r_head_sel  <= in_sel;
        r_head_rd   <= in_rd;
      end

      if (w_enq && (r_occ == 2'd1) && !w_pop) begin
        r_tail_data <= in_data;
        r_tail_sel  <= in_sel;
        r_tail_rd   <= in_rd;
      end

      // Clear wins over a same-edge increment; counters stick at all-ones.
      if (cnt_clr) begin
        for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else if (w_push && (r_cnt[in_sel] != '1)) begin
        r_cnt[in_sel] <= r_cnt[in_sel] + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_head_data;
  assign out_sel   = r_head_sel;
  assign out_rd    = r_head_rd;
  assign occupancy = r_occ;
  assign cnt_value = r_cnt[cnt_sel];

endmodule

// File: tb/tb_wb_capture_stage.sv
// tb/tb_wb_capture_stage.sv - scoreboard bench for wb_capture_stage
module tb_wb_capture_stage;

  localparam int DATA_W = 32;
  localparam int RD_W   = 3;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_sel;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
  logic [RD_W-1:0]   out_rd;
  logic [1:0]        occupancy;
  logic              cnt_clr;
  logic [1:0]        cnt_sel;
  logic [CNT_W-1:0]  cnt_value;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        sel;
    logic [RD_W-1:0]   rd;
  } entry_t;

  entry_t sb[$];
  entry_t exp_e;
  entry_t got_e;
  int checks   = 0;
  int failures = 0;

  wb_capture_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel), .out_rd(out_rd),
    .occupancy(occupancy), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  // Between edges: pops are compared against the queue head, then accepted pushes are queued.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        got_e = '{data: out_data, sel: out_sel, rd: out_rd};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_pop_unexpected got=%h expected=none", got_e);
        end else begin
          exp_e = sb.pop_front();
          if (got_e !== exp_e) begin
            failures++;
            $display("FAIL sb_order got=%h expected=%h", got_e, exp_e);
          end
        end
      end
      if (in_valid && in_ready && (in_rd != '0))
        sb.push_back('{data: in_data, sel: in_sel, rd: in_rd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] s, input logic [RD_W-1:0] r);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_rd    = r;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; cnt_sel = 2'd0;
    drive(1'b0, '0, 2'd0, '0);
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, occupancy} !== 4'b0000 || out_data !== '0 || out_sel !== 2'd0 || out_rd !== '0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b occ=%0d data=%h sel=%0d rd=%0d expected all zero",
               in_ready, out_valid, occupancy, out_data, out_sel, out_rd);
    end
    checks++;
    if (cnt_value !== '0) begin
      failures++;
      $display("FAIL reset_cnt got=%h expected=0", cnt_value);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b expected=1", in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 2'd2, 3'd5);
    tick();
    drive(1'b0, 'x, 2'd0, '0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_sel !== 2'd2 || out_rd !== 3'd5) begin
      failures++;
      $display("FAIL single_out got vld=%b data=%h sel=%0d rd=%0d expected 1 deadbeef 2 5",
               out_valid, out_data, out_sel, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got vld=%b expected=0", out_valid);
    end
    cnt_sel = 2'd2; #1;
    checks++;
    if (cnt_value !== 16'd1) begin
      failures++;
      $display("FAIL single_cnt2 got=%0d expected=1", cnt_value);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    drive(1'b1, 32'h11111111, 2'd0, 3'd1);
    tick();
    drive(1'b1, 32'h22222222, 2'd1, 3'd2);
    tick();
    drive(1'b1, 32'h33333333, 2'd3, 3'd3);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state got occ=%0d rdy=%b expected 2 0", occupancy, in_ready);
    end
    tick();
    checks++;
    if (occupancy !== 2'd2 || out_data !== 32'h11111111) begin
      failures++;
      $display("FAIL full_stall got occ=%0d data=%h expected 2 11111111", occupancy, out_data);
    end
    drive(1'b0, 'x, 2'd0, '0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'h22222222) begin
      failures++;
      $display("FAIL full_pop1 got occ=%0d rdy=%b data=%h expected 1 1 22222222", occupancy, in_ready, out_data);
    end
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_pop2 got occ=%0d vld=%b expected 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    out_ready = 1'b0;
    drive(1'b1, 32'd0, 2'd0, 3'd4);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (out_data !== DATA_W'(i - 1) || occupancy !== 2'd1 || in_ready !== 1'b1) bad++;
      if (i <= 9) drive(1'b1, DATA_W'(i), 2'd0, 3'd4);
      else drive(1'b0, 'x, 2'd0, '0);
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_stream got bad_cycles=%0d expected=0", bad);
    end
    checks++;
    if (occupancy !== 2'd0) begin
      failures++;
      $display("FAIL b2b_drain got occ=%0d expected=0", occupancy);
    end
  endtask

  task automatic test_rd_zero();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hCAFEF00D, 2'd1, 3'd0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd0_ready got=%b expected=1", in_ready);
    end
    tick();
    drive(1'b0, 'x, 2'd0, '0);
    cnt_sel = 2'd1; #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || cnt_value !== 16'd1) begin
      failures++;
      $display("FAIL rd0_effect got vld=%b occ=%0d cnt1=%0d expected 0 0 1", out_valid, occupancy, cnt_value);
    end
  endtask

  task automatic test_saturate();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    cnt_sel = 2'd3;
    drive(1'b1, 32'h0, 2'd3, 3'd0);
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (cnt_value !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_preload got=%h expected=fffe", cnt_value);
    end
    tick();
    checks++;
    if (cnt_value !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_top got=%h expected=ffff", cnt_value);
    end
    tick();
    checks++;
    if (cnt_value !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold got=%h expected=ffff", cnt_value);
    end
    drive(1'b1, 32'h0, 2'd0, 3'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    drive(1'b0, 'x, 2'd0, 'x);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s); #1;
      checks++;
      if (cnt_value !== '0) begin
        failures++;
        $display("FAIL clr_priority cnt[%0d] got=%h expected=0", s, cnt_value);
      end
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL idle_x_ignored got vld=%b occ=%0d expected 0 0", out_valid, occupancy);
    end
    in_rd = '0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA0001, 2'd1, 3'd6);
    tick();
    drive(1'b1, 32'hAAAA0002, 2'd2, 3'd7);
    tick();
    reset_n = 1'b0;
    drive(1'b1, 32'hAAAA0003, 2'd3, 3'd1);
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got occ=%0d vld=%b data=%h rdy=%b expected 0 0 0 0",
               occupancy, out_valid, out_data, in_ready);
    end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s); #1;
      checks++;
      if (cnt_value !== '0) begin
        failures++;
        $display("FAIL midreset_cnt[%0d] got=%h expected=0", s, cnt_value);
      end
    end
    reset_n = 1'b1;
    drive(1'b0, 'x, 2'd0, '0);
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_release got rdy=%b expected=1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_rd_zero();
    test_saturate();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
